// File: rtl/gaa_pkg.sv
// Shared definitions for the GA fitness controller: FSM encoding, register map,
// CTRL/STATUS bit positions and the match-count scoring function.
package gaa_pkg;

  localparam int POP_MAX_DEFAULT = 16;
  localparam int SCORE_W         = 4;
  localparam int POP_SIZE_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] ADDR_TARGET     = 3'd0;
  localparam logic [2:0] ADDR_POP_SIZE   = 3'd1;
  localparam logic [2:0] ADDR_PIDX       = 3'd2;
  localparam logic [2:0] ADDR_PDATA      = 3'd3;
  localparam logic [2:0] ADDR_CTRL       = 3'd4;
  localparam logic [2:0] ADDR_STATUS     = 3'd5;
  localparam logic [2:0] ADDR_BEST_IDX   = 3'd6;
  localparam logic [2:0] ADDR_BEST_SCORE = 3'd7;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;

  // Number of bit positions where the individual agrees with the target.
  function automatic logic [SCORE_W-1:0] match_count(input logic [7:0] a,
                                                     input logic [7:0] b);
    logic [7:0] m;
    m = ~(a ^ b);
    match_count = '0;
    for (int i = 0; i < 8; i++) begin
      match_count = match_count + SCORE_W'(m[i]);
    end
  endfunction

endpackage

// File: rtl/gaa_fitness_score.sv
// Combinational fitness scorer: one individual against the target, 0..8 matches.
module gaa_fitness_score
  import gaa_pkg::*;
(
  input  logic [7:0]         individual,
  input  logic [7:0]         target,
  output logic [SCORE_W-1:0] score
);

  assign score = match_count(individual, target);

endmodule

// File: rtl/gaa_fitness_ctrl.sv
// Bus-mapped GA fitness controller: loads a population, scans it one individual
// per cycle and reports the lowest-index best match against TARGET.
module gaa_fitness_ctrl
  import gaa_pkg::*;
#(
  parameter int POP_MAX = POP_MAX_DEFAULT
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] address,
  input  logic       chipselect,
  input  logic       write,
  input  logic [7:0] writedata,
  input  logic       read,
  output logic [7:0] readdata,
  output logic       irq
);

  localparam int IDX_W = $clog2(POP_MAX);

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_busy;
  logic                  w_done;

  logic [7:0]            r_target;
  logic [POP_SIZE_W-1:0] r_pop_size;
  logic [IDX_W-1:0]      r_pidx;
  logic                  r_irq_en;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_best_idx;
  logic [SCORE_W-1:0]    r_best_score;
  logic [7:0]            r_readdata;
  logic [7:0]            r_pop [POP_MAX];

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_cfg_wr;
  logic                  w_start;
  logic                  w_clear;
  logic                  w_last;
  logic [7:0]            w_eval_ind;
  logic [SCORE_W-1:0]    w_score;
  logic [7:0]            w_rd_mux;

  assign w_wr     = chipselect & write;
  assign w_rd     = chipselect & read & ~write;
  // Configuration and start are locked while a scan is running.
  assign w_cfg_wr = w_wr & ~w_busy;
  assign w_start  = w_cfg_wr && (address == ADDR_CTRL) && writedata[CTRL_START_BIT];
  assign w_clear  = w_wr && (address == ADDR_CTRL) && writedata[CTRL_CLEAR_BIT];
  assign w_last   = (POP_SIZE_W'(r_idx) == (r_pop_size - 1'b1));

  assign w_eval_ind = r_pop[r_idx];

  gaa_fitness_score u_score (
    .individual (w_eval_ind),
    .target     (r_target),
    .score      (w_score)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = (r_pop_size != '0) ? ST_EVAL : ST_DONE;
        end
      end
      ST_EVAL: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Start takes priority over clear_done in the same write.
        if (w_start) begin
          w_state_next = (r_pop_size != '0) ? ST_EVAL : ST_DONE;
        end else if (w_clear) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ST_EVAL);
    w_done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx        <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else if (w_start) begin
      r_idx        <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else if (w_busy) begin
      // Strict compare keeps the lowest index on ties; idx 0 always seeds best.
      if ((r_idx == '0) || (w_score > r_best_score)) begin
        r_best_idx   <= r_idx;
        r_best_score <= w_score;
      end
      r_idx <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_target   <= '0;
      r_pop_size <= '0;
      r_pidx     <= '0;
      r_irq_en   <= 1'b0;
    end else begin
      if (w_cfg_wr && (address == ADDR_TARGET)) begin
        r_target <= writedata;
      end
      if (w_cfg_wr && (address == ADDR_POP_SIZE)) begin
        r_pop_size <= (writedata > 8'(POP_MAX)) ? POP_SIZE_W'(POP_MAX)
                                                : writedata[POP_SIZE_W-1:0];
      end
      if (w_cfg_wr && (address == ADDR_PIDX)) begin
        r_pidx <= writedata[IDX_W-1:0];
      end else if (w_cfg_wr && (address == ADDR_PDATA)) begin
        r_pidx <= (r_pidx == IDX_W'(POP_MAX - 1)) ? '0 : r_pidx + 1'b1;
      end
      if (w_wr && (address == ADDR_CTRL)) begin
        r_irq_en <= writedata[CTRL_IRQEN_BIT];
      end
    end
  end

  // Population storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_cfg_wr && (address == ADDR_PDATA)) begin
      r_pop[r_pidx] <= writedata;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_TARGET:     w_rd_mux = r_target;
      ADDR_POP_SIZE:   w_rd_mux = 8'(r_pop_size);
      ADDR_PIDX:       w_rd_mux = 8'(r_pidx);
      ADDR_PDATA:      w_rd_mux = r_pop[r_pidx];
      ADDR_CTRL:       w_rd_mux[CTRL_IRQEN_BIT] = r_irq_en;
      ADDR_STATUS: begin
        w_rd_mux[STAT_BUSY_BIT] = w_busy;
        w_rd_mux[STAT_DONE_BIT] = w_done;
      end
      ADDR_BEST_IDX:   w_rd_mux = 8'(r_best_idx);
      ADDR_BEST_SCORE: w_rd_mux = 8'(r_best_score);
      default:         w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = w_done & r_irq_en;

endmodule

// File: tb/tb_gaa_fitness_ctrl.sv
// Scoreboard bench for gaa_fitness_ctrl: bus reads push expectations, a monitor
// pops and compares one cycle later; expectations come from a behavioural model.
module tb_gaa_fitness_ctrl;
  import gaa_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] address = '0;
  logic       chipselect = 1'b0;
  logic       write = 1'b0;
  logic [7:0] writedata = '0;
  logic       read = 1'b0;
  logic [7:0] readdata;
  logic       irq;

  always #5 clk = ~clk;

  gaa_fitness_ctrl #(.POP_MAX(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .readdata   (readdata),
    .irq        (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state
  logic [7:0] m_target = '0;
  logic [4:0] m_pop_size = '0;
  logic [3:0] m_pidx = '0;
  logic [7:0] m_pop [16];
  logic       m_irq_en = 1'b0;
  logic       m_done_armed = 1'b0;
  int         m_busy_last = 0;
  logic [3:0] m_best_idx = '0;
  logic [3:0] m_best_score = '0;

  logic [7:0] exp_q [$];
  string      nm_q [$];
  string      anames [8] = '{"TARGET", "POP_SIZE", "PIDX", "PDATA",
                             "CTRL", "STATUS", "BEST_IDX", "BEST_SCORE"};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%02h", name, act);
    end
  endtask

  // A scan started at edge S is busy during edges S+1 .. S+POP_SIZE.
  function automatic logic m_busy_at(input int e);
    return e <= m_busy_last;
  endfunction

  function automatic logic m_done_at(input int e);
    return m_done_armed && (e > m_busy_last);
  endfunction

  function automatic int m_score(input int i);
    logic [7:0] agree;
    agree = ~(m_pop[i] ^ m_target);
    return $countones(agree);
  endfunction

  // Best = maximum score; index = first individual reaching it.
  task automatic m_compute();
    int mx;
    mx = 0;
    for (int i = 0; i < int'(m_pop_size); i++)
      if (m_score(i) > mx) mx = m_score(i);
    m_best_score = 4'(mx);
    m_best_idx   = '0;
    for (int i = int'(m_pop_size) - 1; i >= 0; i--)
      if (m_score(i) == mx) m_best_idx = 4'(i);
  endtask

  function automatic logic [7:0] m_expect(input logic [2:0] a, input int e);
    case (a)
      ADDR_TARGET:     return m_target;
      ADDR_POP_SIZE:   return {3'b0, m_pop_size};
      ADDR_PIDX:       return {4'b0, m_pidx};
      ADDR_PDATA:      return m_pop[m_pidx];
      ADDR_CTRL:       return {5'b0, m_irq_en, 2'b0};
      ADDR_STATUS:     return {6'b0, m_done_at(e), m_busy_at(e)};
      ADDR_BEST_IDX:   return {4'b0, m_best_idx};
      default:         return {4'b0, m_best_score};
    endcase
  endfunction

  function automatic logic m_irq_now();
    return m_irq_en && m_done_armed && (cyc >= m_busy_last);
  endfunction

  // All bus tasks are entered at a negedge and return at the following negedge.
  task automatic wr_core(input logic [2:0] a, input logic [7:0] d, input logic with_rd);
    int   e;
    logic bsy;
    e   = cyc + 1;
    bsy = m_busy_at(e);
    chipselect = 1'b1; write = 1'b1; read = with_rd; address = a; writedata = d;
    $display("[TB] wr %s <= 0x%02h%s", anames[a], d, bsy ? " (busy)" : "");
    if (!bsy) begin
      case (a)
        ADDR_TARGET:   m_target = d;
        ADDR_POP_SIZE: m_pop_size = (d > 8'd16) ? 5'd16 : d[4:0];
        ADDR_PIDX:     m_pidx = d[3:0];
        ADDR_PDATA: begin
          m_pop[m_pidx] = d;
          m_pidx = m_pidx + 4'd1;
        end
        default: ;
      endcase
    end
    if (a == ADDR_CTRL) begin
      if (!bsy && d[0]) begin
        m_busy_last  = e + int'(m_pop_size);
        m_done_armed = 1'b1;
        m_compute();
      end else if (d[1] && m_done_at(e)) begin
        m_done_armed = 1'b0;
      end
      m_irq_en = d[2];
    end
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    wr_core(a, d, 1'b0);
  endtask

  task automatic rd_push(input logic [2:0] a, input logic [7:0] exp, input string nm);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    rd_push(a, m_expect(a, cyc + 1), anames[a]);
  endtask

  task automatic rdx(input logic [2:0] a, input logic [7:0] exp, input string nm);
    rd_push(a, exp, nm);
  endtask

  task automatic load(input logic [7:0] tgt, input logic [7:0] ps, input logic [7:0] vals [$]);
    bus_write(ADDR_TARGET, tgt);
    bus_write(ADDR_POP_SIZE, ps);
    bus_write(ADDR_PIDX, 8'h00);
    foreach (vals[i]) bus_write(ADDR_PDATA, vals[i]);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20; k++) begin
      if (!m_busy_at(cyc + 1)) break;
      rd(ADDR_STATUS);
    end
    rd(ADDR_STATUS);
  endtask

  task automatic do_reset();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    m_target = '0; m_pop_size = '0; m_pidx = '0; m_irq_en = 1'b0;
    m_done_armed = 1'b0; m_busy_last = 0; m_best_idx = '0; m_best_score = '0;
    repeat (2) @(negedge clk);
    chk("rst_readdata", readdata, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 8; a++)
      if (a != int'(ADDR_PDATA)) rdx(3'(a), 8'h00, {tag, "_", anames[a]});
  endtask

  // Monitor: a read sampled at a posedge is compared at the next negedge.
  logic rd_fire;
  always @(posedge clk or negedge reset) begin
    if (!reset) rd_fire <= 1'b0;
    else        rd_fire <= chipselect & read & ~write;
  end

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    string      nm;
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_read: got 0x%02h, expected no read", readdata);
      end else begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        chk(nm, readdata, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [$];
    logic [7:0] rv [$];
    logic       ie;
    int         nb;

    foreach (m_pop[i]) m_pop[i] = '0;
    do_reset();
    check_all_zero("reset");

    // Load, run and interrupt
    bus_write(ADDR_CTRL, 8'h04);
    vals = '{8'h00, 8'hF1, 8'hF0, 8'h0F};
    load(8'hF0, 8'd4, vals);
    bus_write(ADDR_CTRL, 8'h05);
    for (int k = 0; k < 4; k++) rdx(ADDR_STATUS, 8'h01, "run_busy");
    rdx(ADDR_STATUS, 8'h02, "run_done");
    chk("run_irq", {7'b0, irq}, 8'h01);
    rdx(ADDR_BEST_IDX, 8'd2, "run_best_idx");
    rdx(ADDR_BEST_SCORE, 8'd8, "run_best_score");
    rdx(ADDR_CTRL, 8'h04, "ctrl_readback");
    bus_write(ADDR_CTRL, 8'h06);
    rdx(ADDR_STATUS, 8'h00, "clear_status");
    chk("clear_irq", {7'b0, irq}, 8'h00);

    // Ties keep the lowest index
    vals = '{8'hAB, 8'hA8, 8'h00};
    load(8'hAA, 8'd3, vals);
    bus_write(ADDR_CTRL, 8'h05);
    for (int k = 0; k < 3; k++) rdx(ADDR_STATUS, 8'h01, "tie_busy");
    rdx(ADDR_STATUS, 8'h02, "tie_done");
    rdx(ADDR_BEST_IDX, 8'd0, "tie_best_idx");
    rdx(ADDR_BEST_SCORE, 8'd7, "tie_best_score");

    // Limits, wrap and read-during-write hold
    bus_write(ADDR_POP_SIZE, 8'h1F);
    rdx(ADDR_POP_SIZE, 8'd16, "pop_size_sat");
    bus_write(ADDR_PIDX, 8'h00);
    for (int i = 0; i < 17; i++) bus_write(ADDR_PDATA, 8'(8'h30 + i));
    rdx(ADDR_PIDX, 8'd1, "pidx_wrap");
    bus_write(ADDR_PIDX, 8'h00);
    rdx(ADDR_PDATA, 8'h40, "pdata_wrap");
    rd(ADDR_TARGET);
    wr_core(ADDR_POP_SIZE, 8'd0, 1'b1);
    chk("rd_hold", readdata, 8'hAA);
    bus_write(ADDR_CTRL, 8'h06);
    rdx(ADDR_STATUS, 8'h00, "idle_status");
    bus_write(ADDR_CTRL, 8'h05);
    rdx(ADDR_STATUS, 8'h02, "empty_done");
    rdx(ADDR_BEST_SCORE, 8'd0, "empty_best_score");
    rdx(ADDR_BEST_IDX, 8'd0, "empty_best_idx");

    // Writes while busy are ignored
    vals = '{8'h00, 8'hF1, 8'hF0, 8'h0F};
    load(8'hF0, 8'd4, vals);
    bus_write(ADDR_CTRL, 8'h05);
    bus_write(ADDR_TARGET, 8'h00);
    bus_write(ADDR_PDATA, 8'hFF);
    bus_write(ADDR_CTRL, 8'h06);
    rdx(ADDR_STATUS, 8'h01, "busy_still");
    rdx(ADDR_STATUS, 8'h02, "busy_clear_ignored");
    rdx(ADDR_BEST_IDX, 8'd2, "busy_best_idx");
    rdx(ADDR_BEST_SCORE, 8'd8, "busy_best_score");
    rdx(ADDR_TARGET, 8'hF0, "busy_target_kept");
    rdx(ADDR_PIDX, 8'd4, "busy_pidx_kept");
    bus_write(ADDR_CTRL, 8'h06);
    rdx(ADDR_STATUS, 8'h00, "done_cleared");
    chk("done_cleared_irq", {7'b0, irq}, 8'h00);

    // Reset in the middle of a scan
    rv.delete();
    for (int i = 0; i < 16; i++) rv.push_back(8'($urandom));
    load(8'h5A, 8'd16, rv);
    bus_write(ADDR_CTRL, 8'h05);
    @(negedge clk);
    do_reset();
    check_all_zero("midrst");
    load(8'h5A, 8'd16, rv);
    bus_write(ADDR_CTRL, 8'h05);
    wait_done();
    rd(ADDR_BEST_IDX);
    rd(ADDR_BEST_SCORE);

    // Randomised runs against the model
    for (int it = 0; it < 40; it++) begin
      bus_write(ADDR_TARGET, 8'($urandom));
      bus_write(ADDR_POP_SIZE, 8'($urandom_range(0, 24)));
      bus_write(ADDR_PIDX, 8'h00);
      for (int i = 0; i < 16; i++) bus_write(ADDR_PDATA, 8'($urandom));
      bus_write(ADDR_PIDX, 8'($urandom_range(0, 15)));
      rd(ADDR_PDATA);
      rd(ADDR_PIDX);
      rd(ADDR_POP_SIZE);
      ie = 1'($urandom_range(0, 1));
      bus_write(ADDR_CTRL, {5'b0, ie, 2'b01});
      nb = $urandom_range(0, 3);
      for (int k = 0; k < nb; k++)
        bus_write(3'($urandom_range(0, 3)), 8'($urandom));
      wait_done();
      rd(ADDR_BEST_IDX);
      rd(ADDR_BEST_SCORE);
      rd(ADDR_CTRL);
      chk("rand_irq", {7'b0, irq}, {7'b0, m_irq_now()});
      if ($urandom_range(0, 1) == 1) begin
        bus_write(ADDR_CTRL, {5'b0, ie, 2'b10});
        rd(ADDR_STATUS);
      end
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gaa_fitness_ctrl.md
GAA_FITNESS_CTRL -- requirements
Module: gaa_fitness_ctrl

Interface
REQ-001 Parameter POP_MAX, default 16, population buffer depth; index width IDX_W = $clog2(POP_MAX) is derived from it.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset: asserted at 0, released synchronously to clk.
REQ-004 address  input  3  register select.
REQ-005 chipselect  input  1  bus access qualifier.
REQ-006 write  input  1  write strobe, qualified by chipselect.
REQ-007 writedata  input  8  write data.
REQ-008 read  input  1  read strobe, qualified by chipselect.
REQ-009 readdata  output  8  registered read data.
REQ-010 irq  output  1  level interrupt = done & irq_en.

Function
REQ-011 Register map:
- 0 TARGET (rw, 8b).
- 1 POP_SIZE (rw, 5b); a write value above POP_MAX saturates to POP_MAX.
- 2 PIDX (rw, IDX_W b).
- 3 PDATA: a write stores pop[PIDX] and then increments PIDX, wrapping from POP_MAX-1 to 0; a read returns pop[PIDX].
- 4 CTRL: write bit0=start, bit1=clear_done, bit2=irq_en; a read returns {5'b0, irq_en, 2'b0}.
- 5 STATUS (ro): {6'b0, done, busy}.
- 6 BEST_IDX (ro).
- 7 BEST_SCORE (ro, 0..8).
REQ-012 Read: when chipselect & read & !write, readdata is updated at the next edge; readdata holds its value otherwise.
REQ-013 Write: when chipselect & write, the write takes effect at the next edge; a simultaneous read is ignored.
REQ-014 Score of an individual = popcount(~(pop[i] ^ TARGET)), i.e. the count of matching bits, range 0..8, 4 bits wide.
REQ-015 FSM states: IDLE, EVAL, DONE; encoding is a shared enum.
REQ-016 IDLE -> EVAL on a start write when POP_SIZE != 0. That edge sets busy=1, clears done, sets idx=0, best_score=0, best_idx=0.
REQ-017 A start write with POP_SIZE == 0 goes IDLE -> DONE directly: done=1, best_idx=0, best_score=0.
REQ-018 EVAL evaluates one individual per cycle, starting at idx 0.
REQ-019 In EVAL, best is updated only if score(idx) > best_score or idx == 0. The comparison is strict, so ties keep the lowest index.
REQ-020 EVAL -> DONE on the cycle that evaluates idx == POP_SIZE-1. Total EVAL duration is exactly POP_SIZE cycles.
REQ-021 On entering DONE: busy=0, done=1. BEST_IDX and BEST_SCORE are final.
REQ-022 DONE -> IDLE on a clear_done write, which also sets done=0.
REQ-023 In DONE, a start write restarts exactly as from IDLE. If start and clear_done are in the same write, start wins.
REQ-024 While busy, writes to TARGET, POP_SIZE, PIDX, PDATA and start are ignored. irq_en writes are still accepted. Reads are permitted.
REQ-025 irq is combinational from registered done and irq_en; it does not depend on bus inputs.

Reset
REQ-026 Reset values:
- state=IDLE, busy=0, done=0, irq_en=0, irq=0
- TARGET=0, POP_SIZE=0, PIDX=0, idx=0
- BEST_IDX=0, BEST_SCORE=0, readdata=0
REQ-027 Population buffer contents are not reset; they are undefined until written.
REQ-028 Reset asserted mid-EVAL aborts evaluation immediately. After release the block is in IDLE and no done is raised.

Structure
REQ-029 Package gaa_pkg holds:
- the state enum
- register address constants
- CTRL/STATUS bit positions
- POP_MAX default
- score width (4)
REQ-030 One sub-module, gaa_fitness_score: purely combinational, 8b individual + 8b target -> 4b score. It is instantiated once and shared across all indices.
REQ-031 The population buffer is a register array of POP_MAX x 8, read combinationally by idx in EVAL and by PIDX for bus reads.

Verification
REQ-032 Reset then read all 8 addresses -> every value is 0.
REQ-033 Load and start, irq_en=1:
- stimulus: TARGET=0xF0, POP_SIZE=4, pop={0x00,0xF1,0xF0,0x0F}, start.
- response: busy for exactly 4 cycles, then done=1, irq=1, BEST_IDX=2, BEST_SCORE=8.
REQ-034 Tie handling:
- stimulus: TARGET=0xAA, pop={0xAB,0xA8,0x00}, POP_SIZE=3.
- response: BEST_IDX=0 (scores 7,7,4), BEST_SCORE=7.
REQ-035 Limits and wrap:
- POP_SIZE write 0x1F -> reads back 16.
- 17 PDATA writes starting at PIDX=0 -> PIDX=1 and pop[0] holds the 17th value.
- start with POP_SIZE=0 -> done=1 the next cycle, BEST_SCORE=0.
REQ-036 Writes while busy:
- during EVAL, write TARGET=0x00 and PDATA -> both ignored; result matches the unperturbed run.
- clear_done while busy -> no effect.
- clear_done in DONE -> done=0, irq=0, back to IDLE.
REQ-037 Reset mid-EVAL: assert reset on cycle 2 of a POP_SIZE=16 run -> all REQ-026 values, done never asserted, and a subsequent start runs normally.
